async_fifo_read_stream: RTL and testbench



---
 rtl/async_fifo_read_stream.sv | 86 ++++++++
 tb/tb_async_fifo_read_stream.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/async_fifo_read_stream.sv
// Read-side consumer for the asynchronous FIFO: drains the FIFO read port into a
// small credit-checked output buffer and presents it as a valid/ready stream.
module async_fifo_read_stream #(
    parameter int BITS      = 32,
    parameter int OUT_DEPTH = 4,
    parameter int CNT_BITS  = 16
) (
    input  logic                       read_clk,
    input  logic                       read_rst,
    output logic                       p_fifo_read_en,
    input  logic [BITS-1:0]            p_fifo_read_data,
    input  logic                       p_fifo_read_empty,
    output logic                       p_out_valid,
    input  logic                       p_out_ready,
    output logic [BITS-1:0]            p_out_data,
    output logic [$clog2(OUT_DEPTH):0] p_out_count,
    output logic [CNT_BITS-1:0]        p_beat_count
);
    localparam int AW = $clog2(OUT_DEPTH);
    localparam int PW = AW + 1;
    localparam logic [PW:0] DEPTH_C = OUT_DEPTH[PW:0];

    generate
        if (OUT_DEPTH < 2 || (OUT_DEPTH & (OUT_DEPTH - 1)) != 0) begin : g_bad_depth
            $fatal(1, "async_fifo_read_stream: OUT_DEPTH must be a power of two and >= 2");
        end
    endgenerate

    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic            r_inflight;
    logic [BITS-1:0] mem [OUT_DEPTH];
    logic [PW-1:0]   count;
    logic [PW:0]     credit_used;
    logic            pop;

    // Pointers carry one extra bit so a full buffer is distinguishable from an empty one.
    assign count       = wr_ptr - rd_ptr;
    assign credit_used = {1'b0, count} + {{PW{1'b0}}, r_inflight};
    assign pop         = p_out_valid && p_out_ready;

    // NOTE: defaulting every always_comb output before any condition keeps it free of latches.
    always_comb begin
        p_fifo_read_en = 1'b0;
        // A word still in flight already owns a slot, so it counts against the credit.
        if (!read_rst && !p_fifo_read_empty && (credit_used < DEPTH_C)) begin
            p_fifo_read_en = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge read_clk or posedge read_rst) begin
        if (read_rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            r_inflight   <= 1'b0;
            p_beat_count <= '0;
        end else begin
            r_inflight <= p_fifo_read_en;
            if (r_inflight) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr       <= rd_ptr + PW'(1);
                p_beat_count <= p_beat_count + CNT_BITS'(1);
            end
        end
    end

    // NOTE: the buffer is cleared on reset so the head reads 0 while empty; that forces
    // flops here instead of an unreset RAM macro.
    always_ff @(posedge read_clk or posedge read_rst) begin
        if (read_rst) begin
            for (int i = 0; i < OUT_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (r_inflight) begin
            mem[wr_ptr[AW-1:0]] <= p_fifo_read_data;
        end
    end

    assign p_out_count = count;
    assign p_out_valid = (count != '0);
    assign p_out_data  = mem[rd_ptr[AW-1:0]];

endmodule

// File: tb/tb_async_fifo_read_stream.sv
// Self-checking bench: FIFO source model and a queue-level expectation model for two
// builds (OUT_DEPTH=4/CNT_BITS=16 and OUT_DEPTH=2/CNT_BITS=4), plus directed literal checks.
module tb_async_fifo_read_stream;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int          errors = 0;
    int          checks = 0;

    // Build A: OUT_DEPTH = 4, CNT_BITS = 16
    logic        en, empty, valid, ready;
    logic [31:0] rdata, data;
    logic [2:0]  count;
    logic [15:0] beat;

    // Build B: OUT_DEPTH = 2, CNT_BITS = 4
    logic        en2, empty2, valid2, ready2;
    logic [31:0] rdata2, data2;
    logic [1:0]  count2;
    logic [3:0]  beat2;

    always #5 clk = ~clk;

    async_fifo_read_stream #(.BITS(32), .OUT_DEPTH(4), .CNT_BITS(16)) dut (
        .read_clk(clk), .read_rst(rst),
        .p_fifo_read_en(en), .p_fifo_read_data(rdata), .p_fifo_read_empty(empty),
        .p_out_valid(valid), .p_out_ready(ready), .p_out_data(data),
        .p_out_count(count), .p_beat_count(beat)
    );

    async_fifo_read_stream #(.BITS(32), .OUT_DEPTH(2), .CNT_BITS(4)) dut2 (
        .read_clk(clk), .read_rst(rst),
        .p_fifo_read_en(en2), .p_fifo_read_data(rdata2), .p_fifo_read_empty(empty2),
        .p_out_valid(valid2), .p_out_ready(ready2), .p_out_data(data2),
        .p_out_count(count2), .p_beat_count(beat2)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // FIFO source A: words src_mem[0..avail-1], registered read data.
    logic [31:0] src_mem [0:1023];
    int          avail = 0;
    int          rd_idx;
    assign empty = (rd_idx >= avail);

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_idx <= 0;
        end else if (en) begin
            rdata  <= src_mem[rd_idx[9:0]];
            rd_idx <= rd_idx + 1;
        end
    end

    // FIFO source B: word k is 0xC000_0000 + k.
    int avail2 = 0;
    int rd2;
    assign empty2 = (rd2 >= avail2);

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            rd2 <= 0;
        end else if (en2) begin
            rdata2 <= 32'hC000_0000 + rd2;
            rd2    <= rd2 + 1;
        end
    end

    // Model A: occupancy = words returned by the FIFO - words popped; the words read on
    // the last edge are in flight. Output order must equal source order.
    int          out_idx = 0;
    int          prev_rd = 0;
    int          max_count = 0;
    logic        last_stall = 1'b0;
    logic [31:0] last_data = '0;

    always @(negedge clk) begin
        int exp_cnt;
        int infl;
        if (rst) begin
            out_idx    = 0;
            prev_rd    = 0;
            last_stall = 1'b0;
            check("rst_read_en", 32'(en), 32'd0);
            check("rst_valid", 32'(valid), 32'd0);
            check("rst_data", data, 32'd0);
            check("rst_count", 32'(count), 32'd0);
            check("rst_beat", 32'(beat), 32'd0);
        end else begin
            exp_cnt = prev_rd - out_idx;
            infl    = rd_idx - prev_rd;
            if (exp_cnt > max_count) max_count = exp_cnt;
            check("count", 32'(count), 32'(exp_cnt));
            check("valid", 32'(valid), 32'(exp_cnt != 0));
            check("beat", 32'(beat), 32'(out_idx % 65536));
            check("read_en", 32'(en), 32'((rd_idx < avail) && (exp_cnt + infl < 4)));
            if (last_stall) begin
                check("stall_valid", 32'(valid), 32'd1);
                check("stall_data", data, last_data);
            end
            if (valid) check("order_data", data, src_mem[out_idx[9:0]]);
            if (valid && ready) out_idx++;
            last_stall = valid && !ready;
            last_data  = data;
            prev_rd    = rd_idx;
        end
    end

    // Model B: same rules with two slots and a 4-bit beat counter.
    int out2 = 0;
    int prev2 = 0;

    always @(negedge clk) begin
        int e2;
        int i2;
        if (rst) begin
            out2  = 0;
            prev2 = 0;
            check("d2_rst_valid", 32'(valid2), 32'd0);
            check("d2_rst_beat", 32'(beat2), 32'd0);
        end else begin
            e2 = prev2 - out2;
            i2 = rd2 - prev2;
            check("d2_count", 32'(count2), 32'(e2));
            check("d2_valid", 32'(valid2), 32'(e2 != 0));
            check("d2_read_en", 32'(en2), 32'((rd2 < avail2) && (e2 + i2 < 2)));
            check("d2_beat", 32'(beat2), 32'(out2 % 16));
            if (valid2) check("d2_order_data", data2, 32'hC000_0000 + out2);
            if (valid2 && ready2) out2++;
            prev2 = rd2;
        end
    end

    task automatic rst_on();
        @(posedge clk);
        #2 rst = 1'b1;
    endtask

    task automatic rst_off();
        repeat (2) @(negedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int reads;
        int run;
        int max_run;
        int iss;
        int bad;
        logic hist [0:39];

        ready  = 1'b0;
        ready2 = 1'b0;

        // Reset asserted mid-clock while the FIFO is non-empty and words are buffered.
        for (int i = 0; i < 16; i++) src_mem[i] = 32'h1000 + i;
        avail = 16;
        rst_off();
        ready = 1'b1;
        repeat (6) @(posedge clk);
        #1 ready = 1'b0;
        repeat (8) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("rst_imm_read_en", 32'(en), 32'd0);
        check("rst_imm_valid", 32'(valid), 32'd0);
        check("rst_imm_data", data, 32'd0);
        check("rst_imm_count", 32'(count), 32'd0);
        check("rst_imm_beat", 32'(beat), 32'd0);

        // Basic latency: one word, ready high.
        avail      = 0;
        src_mem[0] = 32'hA5A5_0001;
        ready      = 1'b1;
        rst_off();
        repeat (2) @(posedge clk);
        #1 avail = 1;
        @(negedge clk);
        check("lat_c0_read_en", 32'(en), 32'd1);
        check("lat_c0_valid", 32'(valid), 32'd0);
        @(negedge clk);
        check("lat_c1_fifo_data", rdata, 32'hA5A5_0001);
        check("lat_c1_valid", 32'(valid), 32'd0);
        @(negedge clk);
        check("lat_c2_valid", 32'(valid), 32'd1);
        check("lat_c2_data", data, 32'hA5A5_0001);
        check("lat_c2_beat", 32'(beat), 32'd0);
        @(negedge clk);
        check("lat_c3_beat", 32'(beat), 32'd1);
        check("lat_c3_valid", 32'(valid), 32'd0);

        // Streaming: 64 words, ready high, one word per cycle.
        rst_on();
        avail = 0;
        for (int i = 0; i < 64; i++) src_mem[i] = i;
        rst_off();
        @(posedge clk);
        #1 avail = 64;
        run = 0;
        max_run = 0;
        for (int c = 0; c < 80; c++) begin
            @(negedge clk);
            if (valid) begin
                run++;
                if (run > max_run) max_run = run;
            end else begin
                run = 0;
            end
        end
        check("stream_consecutive_valid", 32'(max_run), 32'd64);
        check("stream_beat", 32'(beat), 32'd64);

        // Backpressure: ready low, exactly four reads, then release.
        rst_on();
        avail = 0;
        ready = 1'b0;
        for (int i = 0; i < 100; i++) src_mem[i] = 32'(i * 3 + 7);
        rst_off();
        @(posedge clk);
        #1 avail = 100;
        reads = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (en) reads++;
        end
        check("bp_reads", 32'(reads), 32'd4);
        check("bp_count", 32'(count), 32'd4);
        check("bp_read_en_held", 32'(en), 32'd0);
        check("bp_head", data, 32'd7);
        @(posedge clk);
        #1 ready = 1'b1;
        @(negedge clk);
        check("bp_no_issue_same_cycle", 32'(en), 32'd0);
        @(negedge clk);
        check("bp_resume", 32'(en), 32'd1);
        check("bp_second_word", data, 32'd10);
        repeat (130) @(negedge clk);
        check("bp_beat", 32'(beat), 32'd100);

        // Random ready, 1000 words.
        rst_on();
        avail = 0;
        ready = 1'b0;
        for (int i = 0; i < 1000; i++) src_mem[i] = $urandom();
        rst_off();
        max_count = 0;
        @(posedge clk);
        #1 avail = 1000;
        for (int c = 0; c < 6000 && out_idx < 1000; c++) begin
            @(posedge clk);
            #1 ready = 1'($urandom_range(0, 1));
        end
        @(negedge clk);
        check("rand_words_out", 32'(out_idx), 32'd1000);
        check("rand_beat", 32'(beat), 32'd1000);
        check("rand_max_count_le_4", 32'(max_count <= 4), 32'd1);

        // Build B: two-slot buffer, 17 words, 4-bit counter wraps to 1.
        rst_on();
        ready  = 1'b0;
        ready2 = 1'b1;
        rst_off();
        @(posedge clk);
        #1 avail2 = 17;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            hist[c] = en2;
        end
        check("d2_c0_issue", 32'(hist[0]), 32'd1);
        check("d2_c1_issue", 32'(hist[1]), 32'd1);
        check("d2_block_c1_i1", 32'(hist[2]), 32'd0);
        iss = 0;
        bad = 0;
        for (int c = 0; c < 39; c++) begin
            if (iss < 17 && !hist[c] && !hist[c + 1]) bad++;
            if (hist[c]) iss++;
        end
        check("d2_issue_every_other_cycle", 32'(bad), 32'd0);
        check("d2_issues", 32'(iss), 32'd17);
        check("d2_words_out", 32'(out2), 32'd17);
        check("d2_beat_wrap", 32'(beat2), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
